// File: rtl/dfd_dbg_bus_capture.sv
// Debug bus reader: qualifies debug bus samples and queues them as timestamped trace packets.
// Optional overflow marker entries are enabled by defining DFD_DBG_CAP_OVF_MARKER_EN.
module dfd_dbg_bus_capture #(
  parameter int DEBUG_BUS_WIDTH = 64,
  parameter int FIFO_DEPTH      = 4,
  parameter int COARSE_TS_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DEBUG_BUS_WIDTH-1:0]   debug_bus,
  input  logic                         debug_bus_vld,
  input  logic                         Time_Tick,
  input  logic                         CapEn,
  input  logic                         CapChangeOnly,
  input  logic [DEBUG_BUS_WIDTH-1:0]   CapMask,
  output logic                         pkt_vld,
  input  logic                         pkt_rdy,
  output logic [DEBUG_BUS_WIDTH-1:0]   pkt_data,
  output logic [COARSE_TS_WIDTH+7:0]   pkt_tstamp,
  output logic                         pkt_marker,
  output logic [15:0]                  drop_cnt,
  output logic [1:0]                   cap_state
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int TSW = COARSE_TS_WIDTH + 8;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  function automatic logic masked_change(input logic [DEBUG_BUS_WIDTH-1:0] cur,
                                         input logic [DEBUG_BUS_WIDTH-1:0] prev,
                                         input logic [DEBUG_BUS_WIDTH-1:0] mask);
    return |((cur ^ prev) & mask);
  endfunction

  state_t                       state_r, state_nxt_s;
  logic [7:0]                   fine_r, fine_s;
  logic [COARSE_TS_WIDTH-1:0]   coarse_r, coarse_s;
  logic [DEBUG_BUS_WIDTH-1:0]   last_r;
  logic                         first_sample_r;
  logic [15:0]                  drop_cnt_r;
  logic [DEBUG_BUS_WIDTH-1:0]   mem_data_r [FIFO_DEPTH];
  logic [TSW-1:0]               mem_ts_r   [FIFO_DEPTH];
  logic [AW:0]                  wr_ptr_r, rd_ptr_r;
  logic                         empty_s, full_s, pop_s, push_s, push_hit_s, mk_push_s;
  logic                         hit_s, drop_s, capture_s, arm_s, drain_done_s;
  logic [DEBUG_BUS_WIDTH-1:0]   wr_data_s;
`ifdef DFD_DBG_CAP_OVF_MARKER_EN
  logic                         drop_pending_r;
  logic                         mem_mk_r [FIFO_DEPTH];
`endif

  // Current-cycle timestamp: a tick forces fine to 0 and bumps coarse in the same cycle.
  always_comb begin
    if (Time_Tick) begin
      fine_s   = 8'h00;
      coarse_s = coarse_r + {{(COARSE_TS_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      fine_s   = fine_r + 8'h01;
      coarse_s = coarse_r;
    end
  end

  // Timestamp counters run in every state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fine_r   <= 8'h00;
      coarse_r <= {COARSE_TS_WIDTH{1'b0}};
    end else begin
      fine_r   <= fine_s;
      coarse_r <= coarse_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (CapEn) state_nxt_s = ST_CAPTURE;
        else       state_nxt_s = ST_IDLE;
      end
      ST_CAPTURE: begin
        if (!CapEn) state_nxt_s = ST_DRAIN;
        else        state_nxt_s = ST_CAPTURE;
      end
      ST_DRAIN: begin
        if (drain_done_s) state_nxt_s = ST_IDLE;
        else              state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM decoded outputs.
  always_comb begin
    capture_s = 1'b0;
    arm_s     = 1'b0;
    case (state_r)
      ST_IDLE:    arm_s     = CapEn;
      ST_CAPTURE: capture_s = 1'b1;
      ST_DRAIN:   capture_s = 1'b0;
      default:    capture_s = 1'b0;
    endcase
  end

  assign cap_state = state_r;

  // Sample qualification, FIFO handshake and push arbitration.
  always_comb begin
    empty_s    = (wr_ptr_r == rd_ptr_r);
    full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s      = !empty_s && pkt_rdy;
    hit_s      = capture_s && debug_bus_vld &&
                 (!CapChangeOnly || first_sample_r || masked_change(debug_bus, last_r, CapMask));
    push_hit_s = hit_s && (!full_s || pop_s);
    drop_s     = hit_s && full_s && !pop_s;
`ifdef DFD_DBG_CAP_OVF_MARKER_EN
    mk_push_s    = drop_pending_r && !full_s && !hit_s;
    drain_done_s = empty_s && !drop_pending_r;
`else
    mk_push_s    = 1'b0;
    drain_done_s = empty_s;
`endif
    push_s = push_hit_s || mk_push_s;
    if (push_hit_s) begin
      wr_data_s = debug_bus;
    end else begin
      // Marker payload carries the drop count seen when the marker is written.
      wr_data_s = {{(DEBUG_BUS_WIDTH-16){1'b0}}, drop_cnt_r};
    end
  end

  // Change-detect history, first-sample flag and drop accounting.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_r         <= {DEBUG_BUS_WIDTH{1'b0}};
      first_sample_r <= 1'b0;
      drop_cnt_r     <= 16'h0000;
`ifdef DFD_DBG_CAP_OVF_MARKER_EN
      drop_pending_r <= 1'b0;
`endif
    end else begin
      if (capture_s && debug_bus_vld) begin
        last_r <= debug_bus;
      end
      if (arm_s) begin
        first_sample_r <= 1'b1;
      end else if (capture_s && debug_bus_vld) begin
        first_sample_r <= 1'b0;
      end
      if (arm_s) begin
        drop_cnt_r <= 16'h0000;
      end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'h0001;
      end
`ifdef DFD_DBG_CAP_OVF_MARKER_EN
      if (drop_s) begin
        drop_pending_r <= 1'b1;
      end else if (mk_push_s) begin
        drop_pending_r <= 1'b0;
      end
`endif
    end
  end

  assign drop_cnt = drop_cnt_r;

  // Packet FIFO storage and pointers; reset discards all queued entries.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_r[i] <= {DEBUG_BUS_WIDTH{1'b0}};
        mem_ts_r[i]   <= {TSW{1'b0}};
`ifdef DFD_DBG_CAP_OVF_MARKER_EN
        mem_mk_r[i]   <= 1'b0;
`endif
      end
    end else begin
      if (push_s) begin
        mem_data_r[wr_ptr_r[AW-1:0]] <= wr_data_s;
        mem_ts_r[wr_ptr_r[AW-1:0]]   <= {coarse_s, fine_s};
`ifdef DFD_DBG_CAP_OVF_MARKER_EN
        mem_mk_r[wr_ptr_r[AW-1:0]]   <= !push_hit_s;
`endif
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Head-of-FIFO packet outputs, held while the downstream stalls.
  always_comb begin
    pkt_vld    = !empty_s;
    pkt_data   = mem_data_r[rd_ptr_r[AW-1:0]];
    pkt_tstamp = mem_ts_r[rd_ptr_r[AW-1:0]];
`ifdef DFD_DBG_CAP_OVF_MARKER_EN
    pkt_marker = mem_mk_r[rd_ptr_r[AW-1:0]];
`else
    pkt_marker = 1'b0;
`endif
  end

endmodule

// File: tb/tb_dfd_dbg_bus_capture.sv
// Scoreboard bench for dfd_dbg_bus_capture: directed stimulus queues expected packets,
// an independent monitor compares every accepted packet.
module tb_dfd_dbg_bus_capture;

  localparam int W   = 64;
  localparam int TSW = 24;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [W-1:0]   debug_bus;
  logic           debug_bus_vld;
  logic           Time_Tick;
  logic           CapEn;
  logic           CapChangeOnly;
  logic [W-1:0]   CapMask;
  logic           pkt_vld;
  logic           pkt_rdy;
  logic [W-1:0]   pkt_data;
  logic [TSW-1:0] pkt_tstamp;
  logic           pkt_marker;
  logic [15:0]    drop_cnt;
  logic [1:0]     cap_state;

  always #5 clk = ~clk;

  dfd_dbg_bus_capture #(
    .DEBUG_BUS_WIDTH (W),
    .FIFO_DEPTH      (4),
    .COARSE_TS_WIDTH (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .debug_bus     (debug_bus),
    .debug_bus_vld (debug_bus_vld),
    .Time_Tick     (Time_Tick),
    .CapEn         (CapEn),
    .CapChangeOnly (CapChangeOnly),
    .CapMask       (CapMask),
    .pkt_vld       (pkt_vld),
    .pkt_rdy       (pkt_rdy),
    .pkt_data      (pkt_data),
    .pkt_tstamp    (pkt_tstamp),
    .pkt_marker    (pkt_marker),
    .drop_cnt      (drop_cnt),
    .cap_state     (cap_state)
  );

  typedef struct {
    logic [W-1:0]   data;
    logic [TSW-1:0] ts;
    logic           mk;
    int             due;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [7:0]  fine_m   = 8'h00;
  logic [15:0] coarse_m = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; inputs are already set by the caller.
  task automatic step(input bit push_exp, input bit chk_lat,
                      input bit mk_exp = 1'b0, input logic [15:0] mk_data = 16'h0000);
    logic [7:0]  f;
    logic [15:0] c;
    exp_t        e;
    f = Time_Tick ? 8'h00 : fine_m + 8'h01;
    c = coarse_m + {15'd0, Time_Tick};
    if (push_exp) begin
      e.data = debug_bus; e.ts = {c, f}; e.mk = 1'b0;
      e.due  = chk_lat ? cyc + 1 : -1;
      sb.push_back(e);
    end
    if (mk_exp) begin
      e.data = {48'd0, mk_data}; e.ts = {c, f}; e.mk = 1'b1; e.due = -1;
      sb.push_back(e);
    end
    if (!reset_n) begin
      fine_m = 8'h00; coarse_m = 16'h0000;
    end else begin
      fine_m = f; coarse_m = c;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted packet must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && pkt_vld && pkt_rdy) begin
      exp_t e;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pkt: got data 0x%0h, expected no packet", pkt_data);
      end else begin
        e = sb.pop_front();
        check("pkt_data", pkt_data, e.data);
        check("pkt_tstamp", {40'd0, pkt_tstamp}, {40'd0, e.ts});
        check("pkt_marker", {63'd0, pkt_marker}, {63'd0, e.mk});
        if (e.due >= 0) check("pkt_latency_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    reset_n = 1'b0; debug_bus = '0; debug_bus_vld = 1'b0; Time_Tick = 1'b0;
    CapEn = 1'b0; CapChangeOnly = 1'b0; CapMask = '0; pkt_rdy = 1'b0;
    step(0, 0); step(0, 0);
    reset_n = 1'b1;
    check("reset_pkt_vld", {63'd0, pkt_vld}, 64'd0);
    check("reset_drop_cnt", {48'd0, drop_cnt}, 64'd0);
    check("reset_cap_state", {62'd0, cap_state}, 64'd0);
    check("reset_pkt_marker", {63'd0, pkt_marker}, 64'd0);

    // Always-capture: three samples, one packet each, one cycle later.
    pkt_rdy = 1'b1; CapEn = 1'b1;
    step(0, 0);
    check("arm_cap_state", {62'd0, cap_state}, 64'd1);
    debug_bus_vld = 1'b1;
    debug_bus = 64'h11; step(1, 1);
    debug_bus = 64'h22; step(1, 1);
    debug_bus = 64'h33; step(1, 1);
    debug_bus_vld = 1'b0; step(0, 0);
    CapEn = 1'b0; step(0, 0); step(0, 0);
    check("t1_idle", {62'd0, cap_state}, 64'd0);

    // Change-only with mask 0xFF: 0x200 differs only outside the mask.
    CapChangeOnly = 1'b1; CapMask = 64'hFF; CapEn = 1'b1;
    step(0, 0);
    debug_bus_vld = 1'b1;
    debug_bus = 64'h100; step(1, 1);
    debug_bus = 64'h200; step(0, 0);
    debug_bus = 64'h201; step(1, 1);
    debug_bus_vld = 1'b0; debug_bus = 64'h2FF; step(0, 0);
    CapEn = 1'b0; step(0, 0); step(0, 0);
    CapChangeOnly = 1'b0;

    // Overflow: six hits into a stalled 4-deep FIFO.
    pkt_rdy = 1'b0; CapEn = 1'b1;
    step(0, 0);
    debug_bus_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      debug_bus = 64'hA0 + 64'(i);
      step(i < 4, 0);
    end
    debug_bus_vld = 1'b0; step(0, 0);
    check("ovf_drop_cnt", {48'd0, drop_cnt}, 64'd2);
    check("ovf_pkt_vld", {63'd0, pkt_vld}, 64'd1);
    check("ovf_head_data", pkt_data, 64'hA0);
    step(0, 0);
    check("ovf_head_stable", pkt_data, 64'hA0);
    pkt_rdy = 1'b1;
    step(0, 0);
`ifdef DFD_DBG_CAP_OVF_MARKER_EN
    step(0, 0, 1'b1, 16'd2);
`else
    step(0, 0);
`endif
    for (int i = 0; i < 4; i++) step(0, 0);
    check("ovf_drained", {63'd0, pkt_vld}, 64'd0);
    CapEn = 1'b0; step(0, 0); step(0, 0); step(0, 0);
    check("ovf_idle", {62'd0, cap_state}, 64'd0);

    // Time tick on a hit, then fine counter wrap without a tick.
    CapEn = 1'b1;
    step(0, 0);
    check("rearm_drop_clear", {48'd0, drop_cnt}, 64'd0);
    debug_bus_vld = 1'b1; debug_bus = 64'h55; Time_Tick = 1'b1; step(1, 1);
    Time_Tick = 1'b0; debug_bus = 64'h56; step(1, 1);
    debug_bus_vld = 1'b0;
    for (int i = 0; i < 253; i++) step(0, 0);
    debug_bus_vld = 1'b1;
    debug_bus = 64'h60; step(1, 1);
    debug_bus = 64'h61; step(1, 1);
    debug_bus = 64'h62; step(1, 1);
    debug_bus_vld = 1'b0;
    CapEn = 1'b0; step(0, 0); step(0, 0); step(0, 0);

    // Drain: hits ignored and CapEn ignored until the FIFO empties.
    pkt_rdy = 1'b0; CapEn = 1'b1;
    step(0, 0);
    debug_bus_vld = 1'b1;
    debug_bus = 64'hD1; step(1, 0);
    debug_bus = 64'hD2; step(1, 0);
    debug_bus = 64'hD3; step(1, 0);
    debug_bus_vld = 1'b0; CapEn = 1'b0; step(0, 0);
    check("drain_state", {62'd0, cap_state}, 64'd2);
    debug_bus_vld = 1'b1; debug_bus = 64'hEE; CapEn = 1'b1;
    step(0, 0); step(0, 0);
    check("drain_ignores_capen", {62'd0, cap_state}, 64'd2);
    check("drain_head_stable", pkt_data, 64'hD1);
    debug_bus_vld = 1'b0; CapEn = 1'b0; pkt_rdy = 1'b1;
    step(0, 0); step(0, 0); step(0, 0);
    check("drain_empty_still_drain", {62'd0, cap_state}, 64'd2);
    step(0, 0);
    check("drain_to_idle", {62'd0, cap_state}, 64'd0);

    // Reset mid-capture discards queued entries and clears counters.
    pkt_rdy = 1'b0; CapEn = 1'b1;
    step(0, 0);
    debug_bus_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      debug_bus = 64'hB0 + 64'(i);
      step(0, 0);
    end
    debug_bus_vld = 1'b0; step(0, 0);
    check("pre_rst_pkt_vld", {63'd0, pkt_vld}, 64'd1);
    check("pre_rst_drop_cnt", {48'd0, drop_cnt}, 64'd1);
    check("pre_rst_cap_state", {62'd0, cap_state}, 64'd1);
    reset_n = 1'b0; step(0, 0);
    reset_n = 1'b1; CapEn = 1'b0;
    check("rst_pkt_vld", {63'd0, pkt_vld}, 64'd0);
    check("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
    check("rst_cap_state", {62'd0, cap_state}, 64'd0);

    // Capture still works after the mid-run reset.
    pkt_rdy = 1'b1; CapEn = 1'b1;
    step(0, 0);
    debug_bus_vld = 1'b1; debug_bus = 64'h77; step(1, 1);
    debug_bus_vld = 1'b0; CapEn = 1'b0;
    step(0, 0); step(0, 0); step(0, 0);
    check("final_idle", {62'd0, cap_state}, 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
